// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, command bytes and frame constants.
// Imported by the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake of the PS/2 transmitter.
// The master issues start/txData, the slave reports busy/done/error.
interface ps2_host_tx_if;

    logic       start;
    logic [7:0] txData;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output start, txData,
        input  busy, done, error
    );

    modport slave (
        input  start, txData,
        output busy, done, error
    );

endinterface

// File: rtl/ps2_line_sync.sv
// 2-FF synchronizers for the PS/2 clock and data lines plus a
// falling-edge detector on the synchronized clock.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2Clk_i,
    input  logic ps2Data_i,
    output logic ps2Clk_o,
    output logic ps2Data_o,
    output logic fallEdge_o
);

    logic clkMeta_q;
    logic clkSync_q;
    logic clkPrev_q;
    logic dataMeta_q;
    logic dataSync_q;

    // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clkMeta_q  <= 1'b1;
            clkSync_q  <= 1'b1;
            clkPrev_q  <= 1'b1;
            dataMeta_q <= 1'b1;
            dataSync_q <= 1'b1;
        end else begin
            clkMeta_q  <= ps2Clk_i;
            clkSync_q  <= clkMeta_q;
            clkPrev_q  <= clkSync_q;
            dataMeta_q <= ps2Data_i;
            dataSync_q <= dataMeta_q;
        end
    end

    assign ps2Clk_o   = clkSync_q;
    assign ps2Data_o  = dataSync_q;
    assign fallEdge_o = clkPrev_q & ~clkSync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send,
// device-clocked shift-out of data/parity/stop, then ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_BITS       = 16
) (
    input  logic          clk,
    input  logic          reset,
    ps2_host_tx_if.slave  host,
    input  logic          ps2ClkIn,
    input  logic          ps2DataIn,
    output logic          ps2ClkOe,
    output logic          ps2DataOe
);

    localparam logic [CNT_BITS-1:0] INH_LAST = CNT_BITS'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] TMO_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]          STOP_IDX = 4'(PS2_FRAME_BITS - 2);

    ps2_state_e          state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [3:0]          bitCnt_q;
    logic [8:0]          shReg_q;
    logic                clkOe_q;
    logic                dataOe_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;

    logic clkSync;
    logic dataSync;
    logic fallEdge;
    logic tmo;

    ps2_line_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .ps2Clk_i   (ps2ClkIn),
        .ps2Data_i  (ps2DataIn),
        .ps2Clk_o   (clkSync),
        .ps2Data_o  (dataSync),
        .fallEdge_o (fallEdge)
    );

    assign tmo = (cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitCnt_q <= '0;
            shReg_q  <= '0;
            clkOe_q  <= 1'b0;
            dataOe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    clkOe_q  <= 1'b0;
                    dataOe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (host.start) begin
                        state_q <= INHIBIT;
                        shReg_q <= {odd_parity(host.txData), host.txData};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        clkOe_q <= 1'b1;
                    end
                end
                INHIBIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == INH_LAST) begin
                        state_q  <= RTS;
                        dataOe_q <= 1'b1;
                    end
                end
                RTS: begin
                    state_q  <= SHIFT;
                    clkOe_q  <= 1'b0;
                    bitCnt_q <= '0;
                    cnt_q    <= '0;
                end
                SHIFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (fallEdge) begin
                        cnt_q    <= '0;
                        bitCnt_q <= bitCnt_q + 4'd1;
                        if (bitCnt_q == STOP_IDX) begin
                            dataOe_q <= 1'b0;
                            state_q  <= ACK;
                        end else begin
                            dataOe_q <= ~shReg_q[bitCnt_q];
                        end
                    end else if (tmo) begin
                        state_q  <= IDLE;
                        dataOe_q <= 1'b0;
                        busy_q   <= 1'b0;
                        error_q  <= 1'b1;
                    end
                end
                ACK: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (fallEdge) begin
                        cnt_q <= '0;
                        if (!dataSync) begin
                            state_q <= WAIT_IDLE;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end else if (tmo) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (clkSync && dataSync) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tmo) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    clkOe_q  <= 1'b0;
                    dataOe_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ps2ClkOe   = clkOe_q;
    assign ps2DataOe  = dataOe_q;
    assign host.busy  = busy_q;
    assign host.done  = done_q;
    assign host.error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model with a clocking keyboard
// device, frame contents checked against arithmetic parity/bit rules.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 400;
    localparam int H   = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic devClk = 1'b1;
    logic devData = 1'b1;
    logic ps2ClkOe;
    logic ps2DataOe;
    logic clkLine;
    logic dataLine;

    int nChk = 0;
    int nErr = 0;
    int doneCnt = 0;
    int errCnt = 0;
    int bothCnt = 0;

    ps2_host_tx_if hif();

    assign clkLine  = devClk & ~ps2ClkOe;
    assign dataLine = devData & ~ps2DataOe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_BITS       (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (hif),
        .ps2ClkIn  (clkLine),
        .ps2DataIn (dataLine),
        .ps2ClkOe  (ps2ClkOe),
        .ps2DataOe (ps2DataOe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hif.done)
            doneCnt <= doneCnt + 1;
        if (hif.error)
            errCnt <= errCnt + 1;
        if (hif.done && hif.error)
            bothCnt <= bothCnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_parity(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    task automatic pulse_start(input logic [7:0] b);
        hif.txData = b;
        hif.start  = 1'b1;
        @(negedge clk);
        hif.start  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (hif.busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
    endtask

    // Keyboard model: watches the inhibit, then clocks nClk pulses,
    // sampling the host data on each rising edge.
    task automatic dev_xfer(input bit ack, input int nClk, input int injectAt,
                            output logic [9:0] rx, output int inhLen,
                            output logic startLow);
        int t;
        rx = '1;
        inhLen = 0;
        t = 0;
        while (!ps2ClkOe && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ps2ClkOe)
            check("inhibit_seen", ps2ClkOe, 1);
        while (ps2ClkOe && inhLen < 10 * INH) begin
            @(negedge clk);
            inhLen++;
        end
        startLow = ps2DataOe;
        repeat (5) @(negedge clk);
        for (int i = 0; i < nClk; i++) begin
            if (i == 10 && ack)
                devData = 1'b0;
            devClk = 1'b0;
            repeat (H) @(negedge clk);
            devClk = 1'b1;
            if (i < 10)
                rx[i] = dataLine;
            if (i == injectAt)
                pulse_start(8'hFF);
            repeat (H) @(negedge clk);
            devData = 1'b1;
        end
    endtask

    task automatic do_send(input logic [7:0] b, input int injectAt,
                           input string tag);
        logic [9:0] rx;
        int inhLen;
        logic startLow;
        int d0;
        int e0;
        d0 = doneCnt;
        e0 = errCnt;
        @(negedge clk);
        pulse_start(b);
        check({tag, "_busy_hi"}, hif.busy, 1);
        dev_xfer(1'b1, 11, injectAt, rx, inhLen, startLow);
        wait_idle();
        check({tag, "_data"}, rx[7:0], b);
        check({tag, "_parity"}, rx[8], ref_parity(b));
        check({tag, "_stop"}, rx[9], 1);
        check({tag, "_inh_min"}, inhLen >= INH, 1);
        check({tag, "_inh_max"}, inhLen <= INH + 2, 1);
        check({tag, "_start_low"}, startLow, 1);
        check({tag, "_done"}, doneCnt - d0, 1);
        check({tag, "_err"}, errCnt - e0, 0);
        check({tag, "_busy_lo"}, hif.busy, 0);
        check({tag, "_oe"}, {ps2ClkOe, ps2DataOe}, 0);
    endtask

    initial begin
        logic [9:0] rx;
        int inhLen;
        logic startLow;
        int d0;
        int e0;
        int t;
        int n;

        hif.start  = 1'b0;
        hif.txData = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        hif.txData = 8'hED;
        hif.start  = 1'b1;
        @(negedge clk);
        check("rst_busy", hif.busy, 0);
        check("rst_done", hif.done, 0);
        check("rst_error", hif.error, 0);
        check("rst_oe", {ps2ClkOe, ps2DataOe}, 0);
        hif.start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("start_with_reset", hif.busy, 0);

        do_send(8'hED, -1, "nominal");
        do_send(8'h00, -1, "par00");
        do_send(8'hFF, -1, "parFF");
        do_send(8'h01, -1, "par01");
        for (int k = 0; k < 4; k++)
            do_send(8'($urandom_range(0, 255)), -1, "rand");

        // Missing ACK
        d0 = doneCnt;
        e0 = errCnt;
        @(negedge clk);
        pulse_start(8'h3C);
        dev_xfer(1'b0, 11, -1, rx, inhLen, startLow);
        wait_idle();
        check("noack_data", rx[7:0], 8'h3C);
        check("noack_err", errCnt - e0, 1);
        check("noack_done", doneCnt - d0, 0);
        check("noack_busy", hif.busy, 0);
        check("noack_oe", {ps2ClkOe, ps2DataOe}, 0);

        // Device never clocks
        d0 = doneCnt;
        e0 = errCnt;
        @(negedge clk);
        pulse_start(8'hA5);
        t = 0;
        while (!ps2ClkOe && t < 100) begin
            @(negedge clk);
            t++;
        end
        while (ps2ClkOe && t < 1000) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (!hif.error && n < 2 * TMO) begin
            @(negedge clk);
            n++;
        end
        check("tmo_seen", hif.error, 1);
        check("tmo_time", (n >= TMO - 3) && (n <= TMO + 3), 1);
        check("tmo_oe", {ps2ClkOe, ps2DataOe}, 0);
        repeat (3) @(negedge clk);
        check("tmo_busy", hif.busy, 0);
        check("tmo_err_cnt", errCnt - e0, 1);
        check("tmo_done_cnt", doneCnt - d0, 0);

        // Reset after bit 4 has been shifted
        d0 = doneCnt;
        e0 = errCnt;
        @(negedge clk);
        pulse_start(8'hED);
        dev_xfer(1'b1, 5, -1, rx, inhLen, startLow);
        check("mid_busy", hif.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_oe", {ps2ClkOe, ps2DataOe}, 0);
        check("mid_rst_busy", hif.busy, 0);
        check("mid_rst_pulse", {hif.done, hif.error}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_cnt", (doneCnt - d0) + (errCnt - e0), 0);

        do_send(8'hED, 3, "busy_start");
        repeat (INH + 10) @(negedge clk);
        check("busy_start_no_requeue", hif.busy, 0);

        check("done_error_excl", bothCnt, 0);
        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xFF reset) to the keyboard using the host-request protocol: clock inhibit, request-to-send, device-clocked shift-out, then the ACK bit.
- Shares the open-drain ps2Clk/ps2Data lines with the existing keyboard receiver.
- Asserts busy so the receiver ignores line activity during a transmission.

Parameters:
- INHIBIT_CYCLES, 2500: clk cycles the host holds the clock low (≥100 us at 25 MHz).
- TIMEOUT_CYCLES, 50000: maximum clk cycles allowed between consecutive device clock falling edges, and before the first one (2 ms at 25 MHz).
- CNT_BITS, 16: width of the shared inhibit/timeout counter. Must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to send txData. Ignored unless idle.
- txData  in  8  byte to send, sampled on start.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse: byte sent and device ACKed.
- error  out  1  one-cycle pulse: timeout or missing ACK.
- ps2ClkIn  in  1  raw PS/2 clock line (asynchronous).
- ps2DataIn  in  1  raw PS/2 data line (asynchronous).
- ps2ClkOe  out  1  1 = drive the clock line low, 0 = release.
- ps2DataOe  out  1  1 = drive the data line low, 0 = release.

Behaviour:
- Reset values: busy=0, done=0, error=0, ps2ClkOe=0, ps2DataOe=0, state=IDLE, counters cleared. Reset mid-transfer releases both lines the next cycle.
- Input conditioning:
  - ps2ClkIn and ps2DataIn each pass through a 2-FF synchronizer.
  - fallEdge = previous synchronized clock high AND current low. This adds 3 clk of latency, well inside the ~40 us PS/2 half-period.
- Frame contents:
  - On an accepted start, latch txData into shReg and compute parity = ~^txData (odd parity).
  - The frame shifted after the start bit is: 8 data bits LSB first, parity, stop (released line = 1).
- IDLE:
  - Both lines released.
  - start=1 → INHIBIT, counter=0.
- INHIBIT:
  - ClkOe=1, DataOe=0.
  - The counter increments each cycle. When it reaches INHIBIT_CYCLES-1 → RTS.
- RTS (exactly 1 cycle):
  - ClkOe=1, DataOe=1; this is the start bit.
  - Then → SHIFT with bitCnt=0 and the timeout counter cleared.
- SHIFT:
  - ClkOe=0. DataOe holds its value until the next fallEdge.
  - On each fallEdge: DataOe = ~bit[bitCnt], where bits 0-7 are data and bit 8 is parity. At bitCnt=9, DataOe=0 (stop). Then bitCnt++ and the timeout counter is cleared.
  - The fallEdge that sets the stop bit → ACK.
- ACK:
  - Both lines released.
  - On the next fallEdge, sample synchronized data:
    - 0 → WAIT_IDLE.
    - 1 → error pulse, then IDLE.
- WAIT_IDLE:
  - Wait until synchronized clock=1 AND data=1.
  - Then done pulse (1 cycle) → IDLE.
- Timeout:
  - Applies in SHIFT, ACK and WAIT_IDLE. The counter counts cycles since the last fallEdge, or since RTS.
  - Reaching TIMEOUT_CYCLES → release both lines, error pulse, IDLE.
- busy is 1 in every state except IDLE.
- done and error are never asserted in the same cycle.
- start while busy is ignored; no queueing.
- A device clock edge during INHIBIT or RTS is ignored.
- start together with reset: reset wins.

Decomposition:
- Shared package ps2_pkg:
  - State encoding: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
  - Command constants: PS2_CMD_SET_LEDS=0xED, PS2_CMD_RESET=0xFF, PS2_CMD_RESEND=0xFE, PS2_RSP_ACK=0xFA.
  - PS2_FRAME_BITS=11.
- Sub-module ps2_line_sync: 2-FF synchronizers for both lines plus the falling-edge detector on the clock. The receiver reuses it.

Test Plan:
- Nominal send: start with txData=0xED; the device model clocks at 40 us half-period and ACKs. Required: clock held low ≥INHIBIT_CYCLES, data low before clock release, sampled bits 1,0,1,1,0,1,1,1, parity=1, stop=1, one done pulse, error=0, busy deasserts after the lines return idle.
- Parity: txData=0x00 → parity bit 1; txData=0xFF → parity bit 1; txData=0x01 → parity bit 0.
- No ACK: device leaves data high on the 11th clock → one error pulse, no done, IDLE, both Oe=0.
- Timeout: device never clocks after RTS → error exactly TIMEOUT_CYCLES (±3 sync cycles) after RTS, lines released.
- Reset mid-SHIFT: assert reset after bit 4 → the next cycle has Oe=0, busy=0, and no done or error pulse.
- Start while busy: a second start with 0xFF during SHIFT is ignored; the transmitted byte is still 0xED and exactly one done pulse occurs.
